// File: rtl/qspi_psram_target.sv
// qspi_psram_target: QSPI PSRAM responder used in place of the external serial
// RAM. mem_clk / mem_ce_n / mem_sio_in are oversampled in the sys_clk domain;
// quad read (0xEB) and quad write (0x38) are served from an internal byte store.
// Optional build macro QSPI_ENTER_QUAD_EN: the part powers up in SPI mode,
// 0x35 (serial) enters quad mode and 0xF5 (quad) leaves it.
module qspi_psram_target #(
  parameter int DEPTH    = 65536,
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = 6
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       mem_clk,
  input  logic       mem_ce_n,
  input  logic [3:0] mem_sio_in,
  output logic [3:0] mem_sio_out,
  output logic       mem_sio_oe,
  output logic       quad_mode,
  output logic       cmd_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WAIT, S_RDATA, S_WDATA, S_DROP
  } state_t;

  localparam logic [3:0] WAIT_N = 4'(WAIT_CYC);

  // ---------------------------------------------------------------- input sync
  logic [2:0] clk_sync_q, clk_sync_d;
  logic [2:0] ce_sync_q,  ce_sync_d;
  logic [3:0] sio_s1_q,   sio_s1_d;
  logic [3:0] sio_s2_q,   sio_s2_d;
  logic [1:0] settle_q,   settle_d;

  // Shift the pins into the synchronizers; settle counter masks edges while
  // the chains refill after reset (so a ce_n already low is not seen as a fall).
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], mem_clk};
    ce_sync_d  = {ce_sync_q[1:0], mem_ce_n};
    sio_s1_d   = mem_sio_in;
    sio_s2_d   = sio_s1_q;
    settle_d   = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  end

  // Synchronizer registers; ce_n chain resets to "deselected" so busy reads 0.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      clk_sync_q <= '0;
      ce_sync_q  <= '1;
      sio_s1_q   <= '0;
      sio_s2_q   <= '0;
      settle_q   <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      ce_sync_q  <= ce_sync_d;
      sio_s1_q   <= sio_s1_d;
      sio_s2_q   <= sio_s2_d;
      settle_q   <= settle_d;
    end
  end

  logic       settled, clk_rise, clk_fall, ce_fall, ce_rise;
  logic [3:0] sio;
  assign settled  = (settle_q == 2'd3);
  assign clk_rise = settled &  clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall = settled & ~clk_sync_q[1] &  clk_sync_q[2];
  assign ce_fall  = settled & ~ce_sync_q[1]  &  ce_sync_q[2];
  assign ce_rise  = settled &  ce_sync_q[1]  & ~ce_sync_q[2];
  assign sio      = sio_s2_q;
  assign busy     = ~ce_sync_q[1];

  // ---------------------------------------------------------------- protocol state
  state_t              state_q,   state_d;
  logic [3:0]          cnt_q,     cnt_d;
  logic [3:0]          cmd_hi_q,  cmd_hi_d;
  logic [ADDR_W-1:0]   addr_q,    addr_d;
  logic                is_wr_q,   is_wr_d;
  logic                half_q,    half_d;
  logic                lo_next_q, lo_next_d;
  logic [3:0]          wr_hi_q,   wr_hi_d;
  logic [3:0]          sio_out_q, sio_out_d;
  logic                sio_oe_q,  sio_oe_d;
  logic                err_q,     err_d;
  logic                mem_we;
  logic [7:0]          mem_wdata;
  logic [7:0]          rd_data_q;
  logic [7:0]          cmd_byte;
`ifdef QSPI_ENTER_QUAD_EN
  logic [6:0]          spi_sh_q,    spi_sh_d;
  logic                quad_q,      quad_d;
  logic                quad_set_q,  quad_set_d;
  logic                quad_clr_q,  quad_clr_d;
  logic [7:0]          spi_byte;
`endif

  // Next-state decode: ce_n rise overrides any mem_clk edge in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_hi_d  = cmd_hi_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    half_d    = half_q;
    lo_next_d = lo_next_q;
    wr_hi_d   = wr_hi_q;
    sio_out_d = sio_out_q;
    sio_oe_d  = sio_oe_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_wdata = {wr_hi_q, sio};
    cmd_byte  = {cmd_hi_q, sio};
`ifdef QSPI_ENTER_QUAD_EN
    spi_sh_d   = spi_sh_q;
    quad_d     = quad_q;
    quad_set_d = quad_set_q;
    quad_clr_d = quad_clr_q;
    spi_byte   = {spi_sh_q, sio[0]};
`endif

    if (ce_rise) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      addr_d    = '0;
      half_d    = 1'b0;
      lo_next_d = 1'b0;
      sio_oe_d  = 1'b0;
      sio_out_d = '0;
`ifdef QSPI_ENTER_QUAD_EN
      if (quad_set_q) quad_d = 1'b1;
      if (quad_clr_q) quad_d = 1'b0;
      quad_set_d = 1'b0;
      quad_clr_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ce_fall) begin
            state_d = S_CMD;
            cnt_d   = '0;
          end
        end
        S_CMD: begin
          if (clk_rise) begin
            cnt_d = cnt_q + 4'd1;
`ifdef QSPI_ENTER_QUAD_EN
            if (!quad_q) begin
              spi_sh_d = spi_byte[6:0];
              if (cnt_q == 4'd7) begin
                cnt_d   = '0;
                state_d = S_DROP;
                if (spi_byte == 8'h35) quad_set_d = 1'b1;
                else                   err_d      = 1'b1;
              end
            end else
`endif
            begin
              cmd_hi_d = sio;
              if (cnt_q == 4'd1) begin
                cnt_d = '0;
                if (cmd_byte == 8'hEB) begin
                  state_d = S_ADDR;
                  is_wr_d = 1'b0;
                end else if (cmd_byte == 8'h38) begin
                  state_d = S_ADDR;
                  is_wr_d = 1'b1;
`ifdef QSPI_ENTER_QUAD_EN
                end else if (cmd_byte == 8'hF5) begin
                  state_d    = S_DROP;
                  quad_clr_d = 1'b1;
`endif
                end else begin
                  state_d = S_DROP;
                  err_d   = 1'b1;
                end
              end
            end
          end
        end
        S_ADDR: begin
          // Only the low ADDR_W bits survive the shift; upper address bits fall off.
          if (clk_rise) begin
            addr_d = {addr_q[ADDR_W-5:0], sio};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd5) begin
              cnt_d     = '0;
              half_d    = 1'b0;
              lo_next_d = 1'b0;
              state_d   = is_wr_q ? S_WDATA : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // rd_data_q already holds store[addr] by the time the dummies end.
          if (clk_rise && cnt_q != WAIT_N) cnt_d = cnt_q + 4'd1;
          if (clk_fall && cnt_q == WAIT_N) begin
            sio_oe_d  = 1'b1;
            sio_out_d = rd_data_q[7:4];
            lo_next_d = 1'b1;
            state_d   = S_RDATA;
          end
        end
        S_RDATA: begin
          // Address moves on after the low nibble so the next byte is fetched
          // long before the following fall.
          if (clk_fall) begin
            if (lo_next_q) begin
              sio_out_d = rd_data_q[3:0];
              addr_d    = addr_q + ADDR_W'(1);
              lo_next_d = 1'b0;
            end else begin
              sio_out_d = rd_data_q[7:4];
              lo_next_d = 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (clk_rise) begin
            if (!half_q) begin
              wr_hi_d = sio;
              half_d  = 1'b1;
            end else begin
              mem_we = 1'b1;
              addr_d = addr_q + ADDR_W'(1);
              half_d = 1'b0;
            end
          end
        end
        S_DROP:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Protocol registers.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cmd_hi_q  <= '0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      half_q    <= 1'b0;
      lo_next_q <= 1'b0;
      wr_hi_q   <= '0;
      sio_out_q <= '0;
      sio_oe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_hi_q  <= cmd_hi_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      half_q    <= half_d;
      lo_next_q <= lo_next_d;
      wr_hi_q   <= wr_hi_d;
      sio_out_q <= sio_out_d;
      sio_oe_q  <= sio_oe_d;
      err_q     <= err_d;
    end
  end

`ifdef QSPI_ENTER_QUAD_EN
  // Mode register: SPI after reset, mode changes take effect at ce_n rise.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      spi_sh_q   <= '0;
      quad_q     <= 1'b0;
      quad_set_q <= 1'b0;
      quad_clr_q <= 1'b0;
    end else begin
      spi_sh_q   <= spi_sh_d;
      quad_q     <= quad_d;
      quad_set_q <= quad_set_d;
      quad_clr_q <= quad_clr_d;
    end
  end
  assign quad_mode = quad_q;
`else
  assign quad_mode = 1'b1;
`endif

  // ---------------------------------------------------------------- backing store
  logic [7:0] store_q [DEPTH];

  // Single write port plus registered read of the byte at the current address.
  always_ff @(posedge sys_clk) begin
    if (mem_we) store_q[addr_q] <= mem_wdata;
    rd_data_q <= store_q[addr_q];
  end

  assign mem_sio_out = sio_out_q;
  assign mem_sio_oe  = sio_oe_q;
  assign cmd_err     = err_q;

endmodule
